// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, feeding decode.
// Optional macro MISALIGN_CHK_EN: aligns redirect targets and flags the first word fetched after one.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
`ifdef MISALIGN_CHK_EN
    ,
    output logic        misalign_d
`endif
);

    // Handshake: a word is consumed only in a cycle where imem_valid=1 and neither
    // stall is raised; the memory holds imem_rdata for imem_addr until then.
    logic        acc;
    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] pc_plus4_f;
    logic [31:0] redirect_pc;
    logic [31:0] instr_q, instr_nx;
    logic [31:0] pc_id_q, pc_id_nx;
    logic [31:0] pc_plus4_q, pc_plus4_nx;
    logic        valid_q, valid_nx;
    logic        load_ifid;

    assign acc        = imem_valid & ~stall_f & ~stall_d;
    assign pc_plus4_f = pc_f_q + 32'd4;
    assign load_ifid  = acc & ~flush_d & ~pc_src_e;

`ifdef MISALIGN_CHK_EN
    logic mis_pend_q, mis_pend_d;
    logic misalign_q, misalign_nx;

    assign redirect_pc = {pc_target_e[31:2], 2'b00};

    always_comb begin
        mis_pend_d  = mis_pend_q;
        misalign_nx = 1'b0;
        if (pc_src_e) begin
            mis_pend_d = (pc_target_e[1:0] != 2'b00);
        end else if (stall_d && !flush_d) begin
            misalign_nx = misalign_q;
        end else if (load_ifid) begin
            misalign_nx = mis_pend_q;
            mis_pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_pend_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            mis_pend_q <= mis_pend_d;
            misalign_q <= misalign_nx;
        end
    end

    assign misalign_d = misalign_q;
`else
    assign redirect_pc = pc_target_e;
`endif

    always_comb begin
        pc_f_d = pc_f_q;
        if (pc_src_e) begin
            pc_f_d = redirect_pc;
        end else if (acc) begin
            pc_f_d = pc_plus4_f;
        end
    end

    // Anything that is neither a hold nor an accepted word becomes a bubble.
    always_comb begin
        instr_nx    = NOP_INSTR;
        pc_id_nx    = 32'd0;
        pc_plus4_nx = 32'd0;
        valid_nx    = 1'b0;
        if (flush_d || pc_src_e) begin
            instr_nx = NOP_INSTR;
        end else if (stall_d) begin
            instr_nx    = instr_q;
            pc_id_nx    = pc_id_q;
            pc_plus4_nx = pc_plus4_q;
            valid_nx    = valid_q;
        end else if (acc) begin
            instr_nx    = imem_rdata;
            pc_id_nx    = pc_f_q;
            pc_plus4_nx = pc_plus4_f;
            valid_nx    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f_q     <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc_id_q    <= 32'd0;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            pc_f_q     <= pc_f_d;
            instr_q    <= instr_nx;
            pc_id_q    <= pc_id_nx;
            pc_plus4_q <= pc_plus4_nx;
            valid_q    <= valid_nx;
        end
    end

    assign imem_addr  = pc_f_q;
    assign instr_d    = instr_q;
    assign pc_d       = pc_id_q;
    assign pc_plus4_d = pc_plus4_q;
    assign valid_d    = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, wait states, stalls,
// redirects, address wrap, asynchronous reset and redirect alignment.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall_f, stall_d, flush_d, pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
    logic        valid_d;
`ifdef MISALIGN_CHK_EN
    logic        misalign_d;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d)
`ifdef MISALIGN_CHK_EN
        ,
        .misalign_d  (misalign_d)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: incrementing words, garbage when not valid
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 + (a >> 2);
    endfunction

    assign imem_rdata = imem_valid ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] addr, input logic [31:0] ins,
                            input logic [31:0] pc, input logic [31:0] pc4, input logic v);
        chk({tag, ".imem_addr"}, imem_addr, addr);
        chk({tag, ".instr_d"}, instr_d, ins);
        chk({tag, ".pc_d"}, pc_d, pc);
        chk({tag, ".pc_plus4_d"}, pc_plus4_d, pc4);
        chk({tag, ".valid_d"}, {31'd0, valid_d}, {31'd0, v});
    endtask

    initial begin
        rst_n = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pc_src_e = 1'b0; pc_target_e = 32'd0; imem_valid = 1'b0;
        #12;
        chk_ifid("reset", 32'h0, NOP, 32'h0, 32'h0, 1'b0);
`ifdef MISALIGN_CHK_EN
        chk("reset.misalign_d", {31'd0, misalign_d}, 32'd0);
`endif
        // 1: sequential fetch
        @(posedge clk); #1;
        rst_n = 1'b1; imem_valid = 1'b1;
        chk("t1.addr0", imem_addr, 32'h0);
        tick(); chk_ifid("t1.c1", 32'h4, mem_word(32'h0), 32'h0, 32'h4, 1'b1);
        tick(); chk_ifid("t1.c2", 32'h8, mem_word(32'h4), 32'h4, 32'h8, 1'b1);
        // 2: two wait states at pc 0x8
        imem_valid = 1'b0;
        tick(); chk_ifid("t2.w1", 32'h8, NOP, 32'h0, 32'h0, 1'b0);
        tick(); chk_ifid("t2.w2", 32'h8, NOP, 32'h0, 32'h0, 1'b0);
        imem_valid = 1'b1;
        tick(); chk_ifid("t2.resume", 32'hC, mem_word(32'h8), 32'h8, 32'hC, 1'b1);
        // 3: full stall with 0x10 word in IF/ID
        tick(); chk_ifid("t3.pre", 32'h10, mem_word(32'hC), 32'hC, 32'h10, 1'b1);
        tick(); chk_ifid("t3.at10", 32'h14, mem_word(32'h10), 32'h10, 32'h14, 1'b1);
        stall_f = 1'b1; stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_ifid($sformatf("t3.stall%0d", i), 32'h14, mem_word(32'h10), 32'h10, 32'h14, 1'b1);
        end
        stall_f = 1'b0; stall_d = 1'b0;
        tick(); chk_ifid("t3.resume", 32'h18, mem_word(32'h14), 32'h14, 32'h18, 1'b1);
        // 4: redirect with stall_d in the same cycle
        pc_src_e = 1'b1; pc_target_e = 32'h100; stall_d = 1'b1;
        tick(); chk_ifid("t4.redir", 32'h100, NOP, 32'h0, 32'h0, 1'b0);
        pc_src_e = 1'b0; stall_d = 1'b0;
        tick(); chk_ifid("t4.target", 32'h104, mem_word(32'h100), 32'h100, 32'h104, 1'b1);
        // flush_d alone: word dropped, fetch advances
        flush_d = 1'b1;
        tick(); chk_ifid("t4.flush", 32'h108, NOP, 32'h0, 32'h0, 1'b0);
        flush_d = 1'b0;
        // stall_f alone: PC held, bubble
        stall_f = 1'b1;
        tick(); chk_ifid("t4.stallf", 32'h108, NOP, 32'h0, 32'h0, 1'b0);
        stall_f = 1'b0;
        tick(); chk_ifid("t4.after", 32'h10C, mem_word(32'h108), 32'h108, 32'h10C, 1'b1);
        // 5: wrap at top of address space, then reset mid-stall
        pc_src_e = 1'b1; pc_target_e = 32'hFFFF_FFFC;
        tick(); chk_ifid("t5.redir", 32'hFFFF_FFFC, NOP, 32'h0, 32'h0, 1'b0);
        pc_src_e = 1'b0;
        tick(); chk_ifid("t5.wrap", 32'h0, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0, 1'b1);
        tick(); chk_ifid("t5.post", 32'h4, mem_word(32'h0), 32'h0, 32'h4, 1'b1);
        stall_f = 1'b1; stall_d = 1'b1;
        tick(); chk_ifid("t5.stall", 32'h4, mem_word(32'h0), 32'h0, 32'h4, 1'b1);
        #2; rst_n = 1'b0; #1;
        chk_ifid("t5.async_rst", 32'h0, NOP, 32'h0, 32'h0, 1'b0);
        tick();
        stall_f = 1'b0; stall_d = 1'b0; rst_n = 1'b1;
        tick(); chk_ifid("t5.restart", 32'h4, mem_word(32'h0), 32'h0, 32'h4, 1'b1);
        // 6: misaligned redirect
        pc_src_e = 1'b1; pc_target_e = 32'h102;
        tick();
        pc_src_e = 1'b0;
`ifdef MISALIGN_CHK_EN
        chk("t6.addr", imem_addr, 32'h100);
        chk("t6.bubble_mis", {31'd0, misalign_d}, 32'd0);
        tick(); chk_ifid("t6.w0", 32'h104, mem_word(32'h100), 32'h100, 32'h104, 1'b1);
        chk("t6.w0_mis", {31'd0, misalign_d}, 32'd1);
        tick(); chk("t6.w1_mis", {31'd0, misalign_d}, 32'd0);
        chk("t6.w1_pc", pc_d, 32'h104);
`else
        chk("t6.addr", imem_addr, 32'h102);
        tick(); chk_ifid("t6.w0", 32'h106, mem_word(32'h102), 32'h102, 32'h106, 1'b1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
